// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC instruction-fetch slice.
package npc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: imem request/response, downstream instruction, alu redirect.
interface ifu_fetch_if #(
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [31:0]       imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              redirect_misal;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output redirect_misal
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  redirect_misal
    );
endinterface

// File: rtl/ifu_pc_reg.sv
// Architectural PC register; next-pc priority is redirect, then pc+4, then hold.
module ifu_pc_reg
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic        advance,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = word_align(target);
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, valid/ready to decode, alu redirect.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          INST_W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    ifu_fetch_if.master    bus
);

    ifu_state_e        state, state_next;
    logic              drop, drop_next;
    logic              load_inst;
    logic              advance;
    logic              redirect_en;
    logic [31:0]       pc;
    logic [INST_W-1:0] inst_q;
    logic [31:0]       inst_pc_q;
    logic              misal_q;

    assign redirect_en = bus.redirect_valid && (state != S_IDLE);

    ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (redirect_en),
        .advance  (advance),
        .target   (bus.redirect_pc),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
        end
    end

    always_comb begin
        state_next = state;
        drop_next  = drop;
        load_inst  = 1'b0;
        advance    = 1'b0;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_next = S_WAIT;
                    drop_next  = redirect_en;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    drop_next = 1'b0;
                    // A redirect landing with the response kills it just like a pending drop.
                    if (!drop && !redirect_en) begin
                        load_inst  = 1'b1;
                        state_next = S_OUT;
                    end else begin
                        state_next = S_REQ;
                    end
                end else if (redirect_en) begin
                    drop_next = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_en) begin
                    state_next = S_REQ;
                end else if (bus.inst_ready) begin
                    advance    = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
            misal_q   <= 1'b0;
        end else begin
            if (load_inst) begin
                inst_q    <= bus.imem_rsp_data;
                inst_pc_q <= pc;
            end
            misal_q <= redirect_en && bus.redirect_pc[1];
        end
    end

    assign bus.imem_req_valid = (state == S_REQ);
    assign bus.imem_addr      = pc;
    assign bus.inst_valid     = (state == S_OUT);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.redirect_misal = misal_q;

endmodule
